// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: walks the PC, issues reads to a 1-cycle-latency ROM and
// buffers the returned words (with their PCs) in a small FIFO for the control unit.
module instr_fetch_queue #(
    parameter int          PC_W    = 7,
    parameter int          IW      = 16,
    parameter int          DEPTH   = 2,
    parameter logic [3:0]  HALT_OP = 4'h5
) (
    input  logic            clk,
    input  logic            Reset,
    output logic [PC_W-1:0] IM_Addr,
    output logic            IM_Rd,
    input  logic [IW-1:0]   IM_Data,
    output logic            IR_Valid,
    output logic [IW-1:0]   IR_Data,
    output logic [PC_W-1:0] IR_PC,
    input  logic            IR_Ready,
    input  logic            Redirect,
    input  logic [PC_W-1:0] Redirect_PC,
    output logic            Halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic             squash_q, squash_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IW-1:0]    data_q [DEPTH];
    logic [PC_W-1:0]  pcs_q  [DEPTH];

    logic [OCC_W-1:0] occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    logic             halt_seen;

    // Counting the in-flight read as occupied is what guarantees a ROM word never
    // arrives to a full FIFO.
    always_comb begin
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);
        issue     = !halted_q && !Redirect && (occupancy < OCC_W'(DEPTH));
        push      = inflight_q && !squash_q && !halted_q && !Redirect;
        pop       = (count_q != '0) && IR_Ready && !Redirect;
        halt_seen = push && (IM_Data[IW-1 -: 4] == HALT_OP);
    end

    // NOTE: every *_d gets its hold value first so no path can infer a latch.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        squash_d      = 1'b0;
        halted_d      = halted_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (Redirect) begin
            fetch_pc_d = Redirect_PC;
            squash_d   = inflight_q;
            halted_d   = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue)     fetch_pc_d = fetch_pc_q + PC_W'(1);
            if (push)      tail_d     = tail_q + PTR_W'(1);
            if (pop)       head_d     = head_q + PTR_W'(1);
            if (halt_seen) halted_d   = 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the FIFO storage is reset too, so IR_Data/IR_PC read 0 out of reset.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
            halted_q      <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            halted_q      <= halted_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            if (push) begin
                data_q[tail_q] <= IM_Data;
                pcs_q[tail_q]  <= inflight_pc_q;
            end
        end
    end

    // Reset gates the strobe directly so the ROM sees no read while reset is held.
    assign IM_Rd    = issue && Reset;
    assign IM_Addr  = fetch_pc_q;
    assign IR_Valid = (count_q != '0);
    assign IR_Data  = data_q[head_q];
    assign IR_PC    = pcs_q[head_q];
    assign Halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic, all compared
// each cycle against a queue-based model of the fetch/FIFO behaviour.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [6:0]  IM_Addr;
    logic        IM_Rd;
    logic [15:0] IM_Data = '0;
    logic        IR_Valid;
    logic [15:0] IR_Data;
    logic [6:0]  IR_PC;
    logic        IR_Ready = 1'b0;
    logic        Redirect = 1'b0;
    logic [6:0]  Redirect_PC = '0;
    logic        Halted;

    instr_fetch_queue dut (
        .clk(clk), .Reset(Reset), .IM_Addr(IM_Addr), .IM_Rd(IM_Rd), .IM_Data(IM_Data),
        .IR_Valid(IR_Valid), .IR_Data(IR_Data), .IR_PC(IR_PC), .IR_Ready(IR_Ready),
        .Redirect(Redirect), .Redirect_PC(Redirect_PC), .Halted(Halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency; every read address is logged.
    logic [15:0] rom [128];
    logic [6:0]  rd_log [$];
    always @(posedge clk) begin
        if (IM_Rd) begin
            IM_Data <= rom[IM_Addr];
            rd_log.push_back(IM_Addr);
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [6:0]  pc;
    } entry_t;

    // Reference model: queued words, one optional pending ROM read, next fetch address.
    entry_t m_q [$];
    int     m_pc;
    bit     m_halt;
    bit     m_pend;
    int     m_pend_pc;
    bit     m_drop;

    logic [15:0] pop_data [$];
    logic [6:0]  pop_pc [$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = 0; m_halt = 0; m_pend = 0; m_pend_pc = 0; m_drop = 0;
    endtask

    // Entered and left at a falling edge; asserts reset asynchronously mid-cycle.
    task automatic apply_reset(input int ncyc);
        #2 Reset = 1'b0;
        model_reset();
        #1;
        check("rst_ir_valid", IR_Valid, 0);
        check("rst_im_rd", IM_Rd, 0);
        check("rst_im_addr", IM_Addr, 0);
        check("rst_ir_data", IR_Data, 0);
        check("rst_ir_pc", IR_PC, 0);
        check("rst_halted", Halted, 0);
        repeat (ncyc) @(negedge clk);
        Reset = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rdy, input bit redir, input logic [6:0] rpc);
        bit exp_rd;
        bit do_push;
        IR_Ready = rdy;
        Redirect = redir;
        Redirect_PC = rpc;
        #1;
        exp_rd = !m_halt && !redir && (m_q.size() + int'(m_pend) < 2);
        check("im_rd", IM_Rd, exp_rd);
        check("im_addr", IM_Addr, m_pc);
        check("ir_valid", IR_Valid, m_q.size() > 0);
        check("halted", Halted, m_halt);
        if (m_q.size() > 0) begin
            check("ir_data", IR_Data, m_q[0].data);
            check("ir_pc", IR_PC, m_q[0].pc);
        end
        if (IR_Valid && rdy && !redir) begin
            pop_data.push_back(IR_Data);
            pop_pc.push_back(IR_PC);
        end
        if (redir) begin
            m_q.delete();
            m_pc = rpc;
            m_halt = 0;
            m_drop = m_pend;
            m_pend = 0;
        end else begin
            do_push = m_pend && !m_drop && !m_halt;
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back('{data: rom[m_pend_pc], pc: 7'(m_pend_pc)});
                if (rom[m_pend_pc][15:12] == 4'h5) m_halt = 1;
            end
            m_drop = 0;
            m_pend = exp_rd;
            m_pend_pc = m_pc;
            if (exp_rd) m_pc = (m_pc + 1) % 128;
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        pop_data.delete();
        pop_pc.delete();
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] t1_words [4];
        t1_words = '{16'h1010, 16'h2011, 16'h3201, 16'h5000};
        for (int i = 0; i < 128; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'h5) w[15:12] = 4'h6;
            rom[i] = w;
        end
        for (int i = 0; i < 4; i++) rom[i] = t1_words[i];
        model_reset();
        @(negedge clk);

        // Streaming from reset up to a HALT word at PC 3.
        apply_reset(3);
        clear_logs();
        repeat (12) step(1, 0, '0);
        check("t1_pop_count", pop_data.size(), 4);
        for (int i = 0; i < pop_data.size() && i < 4; i++) begin
            check("t1_pop_data", pop_data[i], t1_words[i]);
            check("t1_pop_pc", pop_pc[i], i);
        end
        check("t2_halted", Halted, 1);
        check("t2_read_count", rd_log.size(), 4);
        for (int i = 0; i < rd_log.size(); i++) check("t2_read_addr", rd_log[i], i);

        // Consumer stall: only two reads fit, then resume without loss or duplication.
        apply_reset(2);
        clear_logs();
        repeat (6) step(0, 0, '0);
        check("t3_stall_reads", rd_log.size(), 2);
        check("t3_held_data", IR_Data, 16'h1010);
        repeat (12) step(1, 0, '0);
        check("t3_reads", rd_log.size(), 4);
        for (int i = 0; i < rd_log.size(); i++) check("t3_read_addr", rd_log[i], i);
        check("t3_pop_count", pop_data.size(), 4);
        for (int i = 0; i < pop_data.size() && i < 4; i++)
            check("t3_pop_data", pop_data[i], t1_words[i]);

        // PC wrap 127 -> 0 after redirect to 126.
        rom[126] = 16'h0111;
        rom[127] = 16'h0222;
        rom[0]   = 16'h0333;
        apply_reset(2);
        step(1, 1, 7'd126);
        clear_logs();
        repeat (8) step(1, 0, '0);
        check("t4_pop_ge3", pop_pc.size() >= 3, 1);
        if (pop_pc.size() >= 3) begin
            check("t4_pc0", pop_pc[0], 126);
            check("t4_pc1", pop_pc[1], 127);
            check("t4_pc2", pop_pc[2], 0);
            check("t4_data2", pop_data[2], 16'h0333);
        end

        // Redirect with a read in flight and a word queued: both discarded.
        apply_reset(2);
        step(0, 1, 7'd5);
        step(0, 0, '0);
        step(0, 0, '0);
        check("t5_pre_valid", IR_Valid, 1);
        step(0, 1, 7'd40);
        check("t5_valid_after", IR_Valid, 0);
        clear_logs();
        repeat (6) step(1, 0, '0);
        check("t5_popped", pop_pc.size() > 0, 1);
        if (pop_pc.size() > 0) check("t5_first_pc", pop_pc[0], 40);

        // Asynchronous reset while the FIFO is full, then fetch restarts at 0.
        rom[0] = 16'h1010;
        apply_reset(2);
        repeat (4) step(0, 0, '0);
        check("t6_full_valid", IR_Valid, 1);
        apply_reset(2);
        clear_logs();
        repeat (3) step(1, 0, '0);
        check("t6_restart_reads", rd_log.size() > 0, 1);
        if (rd_log.size() > 0) check("t6_restart_addr", rd_log[0], 0);

        // Random traffic with sprinkled HALT words, redirects and consumer stalls.
        for (int i = 0; i < 128; i++)
            if ($urandom_range(0, 15) == 0) rom[i][15:12] = 4'h5;
        apply_reset(2);
        for (int n = 0; n < 1500; n++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, 7'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
